// File: rtl/nprime0_mem_arbiter_pkg.sv
// Shared sizing for the n'0 RAM arbiter and its round-robin selector.
package nprime0_mem_arbiter_pkg;

   // Width of one n'0 word (matches the system-wide datapath width).
   localparam int NPR_DATA_WIDTH = 32;
   localparam int NPR_NUM_REQ    = 4;
   localparam int NPR_ADDR_WIDTH = 1;
   // RAM address-to-q latency: input register plus output register.
   localparam int NPR_RD_LATENCY = 2;

   // Lane-id width; kept at least 1 bit so ids are always representable.
   function automatic int lane_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int NPR_LANE_W = lane_w(NPR_NUM_REQ);

endpackage

// File: rtl/nprime0_rr_arb.sv
// Round-robin read selector: scans from the pointer upward and moves the
// pointer one past the granted lane. Grants are suppressed when en_i=0.
module nprime0_rr_arb
   import nprime0_mem_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = NPR_NUM_REQ,
   localparam int LW      = lane_w(NUM_REQ)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [LW-1:0]      id_o
);

   logic [LW-1:0] ptr_q, ptr_d;
   logic          hit;
   logic [LW-1:0] sel;
   int            tmp;

   // Priority scan starting at the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      gnt_o = '0;
      id_o  = '0;
      hit   = 1'b0;
      tmp   = 0;
      sel   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         tmp = int'(ptr_q) + i;
         if (tmp >= NUM_REQ) tmp = tmp - NUM_REQ;
         sel = tmp[LW-1:0];
         if (!hit && req_i[sel]) begin
            hit        = 1'b1;
            gnt_o[sel] = en_i;
            id_o       = sel;
         end
      end
      ptr_d = ptr_q;
      if (hit && en_i)
         ptr_d = (id_o == LW'(NUM_REQ - 1)) ? '0 : id_o + 1'b1;
   end

   // Pointer only advances on an actual grant.
   always_ff @(posedge clock) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/nprime0_mem_arbiter.sv
// Arbitrates one single-port n'0 RAM between NUM_REQ lane readers and a
// throttled host writer; read data returns with a one-hot lane valid.
module nprime0_mem_arbiter
   import nprime0_mem_arbiter_pkg::*;
#(
   parameter  int DATA_WIDTH = NPR_DATA_WIDTH,
   parameter  int NUM_REQ    = NPR_NUM_REQ,
   parameter  int ADDR_WIDTH = NPR_ADDR_WIDTH,
   parameter  int RD_LATENCY = NPR_RD_LATENCY,
   localparam int LW         = lane_w(NUM_REQ)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   input  logic                          host_wr_valid,
   input  logic [ADDR_WIDTH-1:0]         host_wr_addr,
   input  logic [DATA_WIDTH-1:0]         host_wr_data,
   output logic                          host_wr_ready,
   output logic [ADDR_WIDTH-1:0]         mem_address,
   output logic [DATA_WIDTH-1:0]         mem_data,
   output logic                          mem_wren,
   input  logic [DATA_WIDTH-1:0]         mem_q
);

   logic                      throttle_q;
   logic                      wr_acc, rd_en, rd_acc;
   logic [NUM_REQ-1:0]        gnt;
   logic [LW-1:0]             gnt_id;
   logic [ADDR_WIDTH-1:0]     rd_addr;
   logic [ADDR_WIDTH-1:0]     mem_address_q;
   logic [DATA_WIDTH-1:0]     mem_data_q;
   logic                      mem_wren_q;
   // Tag pipeline: stage 0 captured at acceptance, stage RD_LATENCY lines up with mem_q.
   logic [RD_LATENCY:0]         vld_pipe_q;
   logic [RD_LATENCY:0][LW-1:0] id_pipe_q;

   // A write blocks all reads this cycle; the throttle leaves a read slot after it.
   assign host_wr_ready = !reset && !throttle_q;
   assign wr_acc        = host_wr_valid && host_wr_ready;
   assign rd_en         = !reset && !wr_acc;

   nprime0_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr (
      .clock (clock),
      .reset (reset),
      .req_i (req_valid),
      .en_i  (rd_en),
      .gnt_o (gnt),
      .id_o  (gnt_id)
   );

   assign req_ready = gnt;
   assign rd_acc    = |gnt;

   // Address of the granted lane.
   always_comb begin
      rd_addr = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (gnt[i]) rd_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
   end

   // RAM port registers, write throttle and read tag pipeline.
   always_ff @(posedge clock) begin
      if (reset) begin
         throttle_q    <= 1'b0;
         mem_address_q <= '0;
         mem_data_q    <= '0;
         mem_wren_q    <= 1'b0;
         vld_pipe_q    <= '0;
         id_pipe_q     <= '0;
      end else begin
         throttle_q <= wr_acc;
         mem_wren_q <= wr_acc;
         if (wr_acc) begin
            mem_address_q <= host_wr_addr;
            mem_data_q    <= host_wr_data;
         end else if (rd_acc) begin
            mem_address_q <= rd_addr;
         end
         vld_pipe_q <= {vld_pipe_q[RD_LATENCY-1:0], rd_acc};
         id_pipe_q  <= {id_pipe_q[RD_LATENCY-1:0], gnt_id};
      end
   end

   assign mem_address = mem_address_q;
   assign mem_data    = mem_data_q;
   assign mem_wren    = mem_wren_q;

   // Decode the oldest tag into the one-hot response valid.
   always_comb begin
      rsp_valid = '0;
      if (vld_pipe_q[RD_LATENCY]) rsp_valid[id_pipe_q[RD_LATENCY]] = 1'b1;
   end

   assign rsp_data = mem_q;

endmodule

// File: tb/tb_nprime0_mem_arbiter.sv
// Directed bench for nprime0_mem_arbiter with a 2-cycle registered RAM model.
module tb_nprime0_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_addr;
   logic [3:0]  req_ready;
   logic [3:0]  rsp_valid;
   logic [31:0] rsp_data;
   logic        host_wr_valid;
   logic        host_wr_addr;
   logic [31:0] host_wr_data;
   logic        host_wr_ready;
   logic        mem_address;
   logic [31:0] mem_data;
   logic        mem_wren;
   logic [31:0] mem_q;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   nprime0_mem_arbiter dut (
      .clock         (clock),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_ready     (req_ready),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .host_wr_valid (host_wr_valid),
      .host_wr_addr  (host_wr_addr),
      .host_wr_data  (host_wr_data),
      .host_wr_ready (host_wr_ready),
      .mem_address   (mem_address),
      .mem_data      (mem_data),
      .mem_wren      (mem_wren),
      .mem_q         (mem_q)
   );

   // RAM model: registered address, registered q, write through the input register.
   logic [31:0] ram [2];
   logic        ram_addr_r;
   always @(posedge clock) begin
      if (mem_wren) ram[mem_address] <= mem_data;
      ram_addr_r <= mem_address;
      mem_q      <= ram[ram_addr_r];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid     = '0;
      req_addr      = '0;
      host_wr_valid = 1'b0;
      host_wr_addr  = 1'b0;
      host_wr_data  = '0;
   endtask

   // Two reset edges; returns in cycle 0 with reset released and inputs idle.
   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   logic [3:0] exp_rv;

   initial begin
      // ---------------- reset behaviour ----------------
      reset = 1'b1;
      idle_inputs();
      req_valid     = 4'b1111;
      host_wr_valid = 1'b1;
      #2;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_wr_ready", 32'(host_wr_ready), 32'h0);
      tick();
      tick();
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_wren", 32'(mem_wren), 32'h0);
      chk("rst_addr", 32'(mem_address), 32'h0);
      chk("rst_data", mem_data, 32'h0);
      chk("rst_req_ready2", 32'(req_ready), 32'h0);
      reset = 1'b0;
      idle_inputs();

      // ---------------- T1: write then lane 2 read ----------------
      host_wr_valid = 1'b1; host_wr_addr = 1'b0; host_wr_data = 32'h89ABCDEF;
      #1;
      chk("t1_wr_ready0", 32'(host_wr_ready), 32'h1);
      tick();
      host_wr_valid = 1'b0;
      req_valid = 4'b0100; req_addr = 4'b0000;
      #1;
      chk("t1_wren", 32'(mem_wren), 32'h1);
      chk("t1_wdata", mem_data, 32'h89ABCDEF);
      chk("t1_wr_ready1", 32'(host_wr_ready), 32'h0);
      chk("t1_rd_grant", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      #1;
      chk("t1_wren_off", 32'(mem_wren), 32'h0);
      chk("t1_wr_ready2", 32'(host_wr_ready), 32'h1);
      tick();
      chk("t1_rsp_early", 32'(rsp_valid), 32'h0);
      tick();
      chk("t1_rsp_valid", 32'(rsp_valid), 32'h4);
      chk("t1_rsp_data", rsp_data, 32'h89ABCDEF);
      tick();
      chk("t1_rsp_once", 32'(rsp_valid), 32'h0);

      // ---------------- T2: all lanes, round robin ----------------
      do_reset();
      for (int n = 0; n <= 10; n++) begin
         req_valid = (n < 8) ? 4'b1111 : 4'b0000;
         #1;
         if (n < 8) chk($sformatf("t2_grant%0d", n), 32'(req_ready), 32'(4'b0001 << (n % 4)));
         exp_rv = (n >= 3) ? (4'b0001 << ((n - 3) % 4)) : 4'b0000;
         chk($sformatf("t2_rsp%0d", n), 32'(rsp_valid), 32'(exp_rv));
         tick();
      end
      req_valid = '0;

      // ---------------- T3: continuous writes, lanes 1 and 3 ----------------
      do_reset();
      for (int n = 0; n <= 11; n++) begin
         host_wr_valid = (n < 8);
         host_wr_addr  = 1'b1;
         host_wr_data  = 32'h00000011;
         req_valid     = (n < 8) ? 4'b1010 : 4'b0000;
         req_addr      = 4'b1111;
         #1;
         if (n < 8) begin
            chk($sformatf("t3_wr_ready%0d", n), 32'(host_wr_ready), 32'((n % 2) == 0));
            chk($sformatf("t3_grant%0d", n), 32'(req_ready),
                (n % 2 == 0) ? 32'h0 : ((n % 4 == 1) ? 32'h2 : 32'h8));
         end
         if (n >= 4 && n <= 10 && n % 2 == 0) exp_rv = ((n - 3) % 4 == 1) ? 4'b0010 : 4'b1000;
         else                                 exp_rv = 4'b0000;
         chk($sformatf("t3_rsp%0d", n), 32'(rsp_valid), 32'(exp_rv));
         if (exp_rv != 4'b0000) chk($sformatf("t3_data%0d", n), rsp_data, 32'h00000011);
         tick();
      end
      idle_inputs();

      // ---------------- T4: lane 0 back-to-back reads ----------------
      do_reset();
      for (int n = 0; n <= 8; n++) begin
         req_valid = (n < 5) ? 4'b0001 : 4'b0000;
         req_addr  = 4'b0001;
         #1;
         if (n < 5) chk($sformatf("t4_grant%0d", n), 32'(req_ready), 32'h1);
         exp_rv = (n >= 3 && n <= 7) ? 4'b0001 : 4'b0000;
         chk($sformatf("t4_rsp%0d", n), 32'(rsp_valid), 32'(exp_rv));
         if (exp_rv != 4'b0000) chk($sformatf("t4_data%0d", n), rsp_data, 32'h00000011);
         tick();
      end
      idle_inputs();

      // ---------------- T5: reset discards in-flight reads ----------------
      do_reset();
      req_valid = 4'b0011; req_addr = 4'b1111;
      #1;
      chk("t5_grant0", 32'(req_ready), 32'h1);
      tick();
      chk("t5_grant1", 32'(req_ready), 32'h2);
      tick();
      reset = 1'b1;
      req_valid = '0;
      #1;
      chk("t5_rst_ready", 32'(req_ready), 32'h0);
      tick();
      reset = 1'b0;
      #1;
      chk("t5_rsp_kill0", 32'(rsp_valid), 32'h0);
      chk("t5_addr0", 32'(mem_address), 32'h0);
      chk("t5_wren0", 32'(mem_wren), 32'h0);
      chk("t5_data0", mem_data, 32'h0);
      chk("t5_wr_ready", 32'(host_wr_ready), 32'h1);
      tick();
      req_valid = 4'b1111;
      #1;
      chk("t5_rsp_kill1", 32'(rsp_valid), 32'h0);
      chk("t5_first_grant", 32'(req_ready), 32'h1);
      tick();
      idle_inputs();

      // ---------------- T6: same-cycle write and lane 1 read ----------------
      do_reset();
      host_wr_valid = 1'b1; host_wr_addr = 1'b0; host_wr_data = 32'h5;
      req_valid = 4'b0010; req_addr = 4'b0000;
      #1;
      chk("t6_wr_ready", 32'(host_wr_ready), 32'h1);
      chk("t6_rd_stall", 32'(req_ready), 32'h0);
      tick();
      host_wr_valid = 1'b0;
      #1;
      chk("t6_rd_grant", 32'(req_ready), 32'h2);
      chk("t6_wren", 32'(mem_wren), 32'h1);
      chk("t6_wdata", mem_data, 32'h5);
      tick();
      req_valid = '0;
      #1;
      chk("t6_no_regrant", 32'(req_ready), 32'h0);
      tick();
      chk("t6_rsp_early", 32'(rsp_valid), 32'h0);
      tick();
      chk("t6_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("t6_rsp_data", rsp_data, 32'h5);
      tick();
      chk("t6_rsp_once", 32'(rsp_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
